// File: rtl/calc_op_master.sv
// Command initiator for the calc5 operand/result handshake: issues one op, collects the
// result, checks it against a locally computed expectation and reports it upstream.
module calc_op_master #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [1:0]       calc_ctrl,
  output logic [WIDTH-1:0] calc_a,
  output logic [WIDTH-1:0] calc_b,
  output logic             calc_din_valid,
  input  logic             calc_stall_out,
  output logic             calc_stall_in,
  input  logic [WIDTH-1:0] calc_out,
  input  logic             calc_dout_valid,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [1:0]       res_op,
  output logic             res_err,
  output logic             res_dz,
  output logic             res_timeout,
  output logic [CNT_W-1:0] op_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES, REPORT} state_t;

  localparam int            TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_reg;
  logic [TW-1:0]    timer_reg;
  logic [WIDTH-1:0] expected_reg;
  logic [WIDTH-1:0] expected_next;
  logic             dz_reg;
  logic             dz_next;

  assign cmd_ready     = (state_reg == IDLE);
  assign calc_stall_in = (state_reg == WAIT_RES);

  // Division by zero is guarded so the expectation never goes X; its result is not checked.
  always_comb begin
    expected_next = '0;
    dz_next       = 1'b0;
    case (cmd_op)
      2'd0: expected_next = cmd_a + cmd_b;
      2'd1: expected_next = cmd_a - cmd_b;
      2'd2: expected_next = cmd_a * cmd_b;
      default: begin
        if (cmd_b == '0) begin
          dz_next = 1'b1;
        end else begin
          expected_next = cmd_a / cmd_b;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      timer_reg      <= '0;
      expected_reg   <= '0;
      dz_reg         <= 1'b0;
      calc_ctrl      <= '0;
      calc_a         <= '0;
      calc_b         <= '0;
      calc_din_valid <= 1'b0;
      res_valid      <= 1'b0;
      res_data       <= '0;
      res_op         <= '0;
      res_err        <= 1'b0;
      res_dz         <= 1'b0;
      res_timeout    <= 1'b0;
      op_cnt         <= '0;
      err_cnt        <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            calc_ctrl      <= cmd_op;
            calc_a         <= cmd_a;
            calc_b         <= cmd_b;
            expected_reg   <= expected_next;
            dz_reg         <= dz_next;
            timer_reg      <= '0;
            calc_din_valid <= 1'b1;
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          if (calc_stall_out) begin
            calc_din_valid <= 1'b0;
            if (op_cnt != CNT_MAX) op_cnt <= op_cnt + 1'b1;
            timer_reg      <= '0;
            state_reg      <= WAIT_RES;
          end else if (timer_reg == TIMER_LAST) begin
            calc_din_valid <= 1'b0;
            res_data       <= '0;
            res_op         <= calc_ctrl;
            res_err        <= 1'b0;
            res_dz         <= dz_reg;
            res_timeout    <= 1'b1;
            res_valid      <= 1'b1;
            state_reg      <= REPORT;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        WAIT_RES: begin
          if (calc_dout_valid) begin
            res_data    <= calc_out;
            res_op      <= calc_ctrl;
            res_err     <= (calc_out != expected_reg) && !dz_reg;
            res_dz      <= dz_reg;
            res_timeout <= 1'b0;
            res_valid   <= 1'b1;
            state_reg   <= REPORT;
          end else if (timer_reg == TIMER_LAST) begin
            res_data    <= '0;
            res_op      <= calc_ctrl;
            res_err     <= 1'b0;
            res_dz      <= dz_reg;
            res_timeout <= 1'b1;
            res_valid   <= 1'b1;
            state_reg   <= REPORT;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        default: begin
          // REPORT: every res_* output holds until upstream takes it.
          if (res_ready) begin
            res_valid <= 1'b0;
            if ((res_err || res_timeout) && (err_cnt != CNT_MAX)) err_cnt <= err_cnt + 1'b1;
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_op_master.sv
// Directed bench for calc_op_master: the bench plays both the upstream source and calc5.
module tb_calc_op_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [1:0]  calc_ctrl;
  logic [31:0] calc_a;
  logic [31:0] calc_b;
  logic        calc_din_valid;
  logic        calc_stall_out;
  logic        calc_stall_in;
  logic [31:0] calc_out;
  logic        calc_dout_valid;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [1:0]  res_op;
  logic        res_err;
  logic        res_dz;
  logic        res_timeout;
  logic [15:0] op_cnt;
  logic [15:0] err_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  calc_op_master #(.WIDTH(32), .TIMEOUT(64), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .calc_ctrl(calc_ctrl), .calc_a(calc_a), .calc_b(calc_b), .calc_din_valid(calc_din_valid),
    .calc_stall_out(calc_stall_out), .calc_stall_in(calc_stall_in), .calc_out(calc_out),
    .calc_dout_valid(calc_dout_valid),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_op(res_op),
    .res_err(res_err), .res_dz(res_dz), .res_timeout(res_timeout),
    .op_cnt(op_cnt), .err_cnt(err_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete operation; calc answers calc_result on the first WAIT_RES edge.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] calc_result,
                       input int stall_cycles, input int ready_wait,
                       input logic [31:0] exp_data, input logic exp_err, input logic exp_dz);
    int held;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    calc_stall_out  = (stall_cycles == 0);
    calc_dout_valid = (stall_cycles == 0);
    calc_out = calc_result;
    tick();
    cmd_valid = 1'b0; cmd_a = 32'hDEAD_BEEF; cmd_b = 32'hDEAD_BEEF;
    chk({tag, ".din_valid"}, calc_din_valid, 1'b1);
    chk({tag, ".ctrl"}, calc_ctrl, op);
    chk({tag, ".calc_a"}, calc_a, a);
    chk({tag, ".calc_b"}, calc_b, b);
    held = 1;
    for (int i = 0; i < stall_cycles; i++) begin
      tick();
      if (calc_din_valid === 1'b1) held++;
      chk({tag, ".a_stable"}, calc_a, a);
      chk({tag, ".b_stable"}, calc_b, b);
    end
    if (stall_cycles > 0) chk({tag, ".din_held"}, held, stall_cycles + 1);
    calc_stall_out = 1'b1; calc_dout_valid = 1'b1;
    tick();
    calc_stall_out = 1'b0;
    chk({tag, ".din_drop"}, calc_din_valid, 1'b0);
    chk({tag, ".stall_in"}, calc_stall_in, 1'b1);
    chk({tag, ".no_early_res"}, res_valid, 1'b0);
    tick();
    calc_dout_valid = 1'b0;
    chk({tag, ".res_valid"}, res_valid, 1'b1);
    chk({tag, ".res_data"}, res_data, exp_data);
    chk({tag, ".res_op"}, res_op, op);
    chk({tag, ".res_err"}, res_err, exp_err);
    chk({tag, ".res_dz"}, res_dz, exp_dz);
    chk({tag, ".res_timeout"}, res_timeout, 1'b0);
    for (int i = 0; i < ready_wait; i++) begin
      tick();
      chk({tag, ".res_hold"}, res_valid, 1'b1);
      chk({tag, ".data_hold"}, res_data, exp_data);
      chk({tag, ".cmd_ready_low"}, cmd_ready, 1'b0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, ".res_done"}, res_valid, 1'b0);
    chk({tag, ".cmd_ready"}, cmd_ready, 1'b1);
    $display("op %s: a=%0h b=%0h res=%0h err=%0b dz=%0b op_cnt=%0d err_cnt=%0d",
             tag, a, b, res_data, res_err, res_dz, op_cnt, err_cnt);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    calc_stall_out = 1'b0; calc_out = '0; calc_dout_valid = 1'b0; res_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst.cmd_ready", cmd_ready, 1'b1);
    chk("rst.din_valid", calc_din_valid, 1'b0);
    chk("rst.stall_in", calc_stall_in, 1'b0);
    chk("rst.res_valid", res_valid, 1'b0);
    chk("rst.op_cnt", op_cnt, 16'd0);
    chk("rst.err_cnt", err_cnt, 16'd0);

    do_op("add", 2'd0, 32'd4, 32'd2, 32'd6, 0, 0, 32'd6, 1'b0, 1'b0);
    chk("add.op_cnt", op_cnt, 16'd1);
    do_op("sub", 2'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 0, 0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    do_op("mul", 2'd2, 32'd5, 32'd150, 32'd750, 3, 0, 32'd750, 1'b0, 1'b0);
    do_op("div", 2'd3, 32'd72, 32'd9, 32'd8, 0, 4, 32'd8, 1'b0, 1'b0);
    do_op("div0", 2'd3, 32'd7, 32'd0, 32'd0, 0, 0, 32'd0, 1'b0, 1'b1);
    chk("div0.err_cnt", err_cnt, 16'd0);
    do_op("bad_add", 2'd0, 32'd3, 32'd3, 32'd7, 0, 0, 32'd7, 1'b1, 1'b0);
    chk("bad_add.err_cnt", err_cnt, 16'd1);
    do_op("div0_any", 2'd3, 32'd7, 32'd0, 32'd5, 0, 0, 32'd5, 1'b0, 1'b1);
    chk("div0_any.op_cnt", op_cnt, 16'd7);
    chk("div0_any.err_cnt", err_cnt, 16'd1);

    // Timeout in WAIT_RES: calc accepts but never answers.
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_a = 32'd1; cmd_b = 32'd1; calc_stall_out = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    calc_stall_out = 1'b0;
    chk("to_wait.stall_in", calc_stall_in, 1'b1);
    for (int i = 1; i < 64; i++) tick();
    chk("to_wait.not_yet", res_valid, 1'b0);
    tick();
    chk("to_wait.res_valid", res_valid, 1'b1);
    chk("to_wait.res_timeout", res_timeout, 1'b1);
    chk("to_wait.res_data", res_data, 32'd0);
    chk("to_wait.res_err", res_err, 1'b0);
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    chk("to_wait.err_cnt", err_cnt, 16'd2);
    chk("to_wait.op_cnt", op_cnt, 16'd8);
    $display("op timeout_wait: op_cnt=%0d err_cnt=%0d", op_cnt, err_cnt);

    // Timeout in ISSUE: calc never accepts the operands.
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_a = 32'd9; cmd_b = 32'd9;
    tick();
    cmd_valid = 1'b0;
    for (int i = 1; i < 64; i++) tick();
    chk("to_issue.din_held", calc_din_valid, 1'b1);
    tick();
    chk("to_issue.din_drop", calc_din_valid, 1'b0);
    chk("to_issue.res_timeout", res_timeout, 1'b1);
    chk("to_issue.res_op", res_op, 2'd2);
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    chk("to_issue.op_cnt", op_cnt, 16'd8);
    chk("to_issue.err_cnt", err_cnt, 16'd3);
    $display("op timeout_issue: op_cnt=%0d err_cnt=%0d", op_cnt, err_cnt);

    // Reset pulsed while waiting for a result.
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_a = 32'd2; cmd_b = 32'd2; calc_stall_out = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    calc_stall_out = 1'b0;
    chk("rst2.in_wait", calc_stall_in, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst2.cmd_ready", cmd_ready, 1'b1);
    chk("rst2.stall_in", calc_stall_in, 1'b0);
    chk("rst2.res_valid", res_valid, 1'b0);
    chk("rst2.calc_a", calc_a, 32'd0);
    chk("rst2.op_cnt", op_cnt, 16'd0);
    chk("rst2.err_cnt", err_cnt, 16'd0);
    $display("op reset_mid_op: cmd_ready=%0b op_cnt=%0d", cmd_ready, op_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
